iob_fifo_sync_t2p_ctrl: RTL



---
 rtl/iob_fifo_sync_t2p_ctrl_pkg.sv | 22 ++
 rtl/iob_fifo_sync_t2p_ctrl_if.sv | 34 +++
 rtl/iob_counter_updown.sv | 38 +++
 rtl/iob_fifo_sync_t2p_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/iob_fifo_sync_t2p_ctrl_pkg.sv
// Shared definitions for the t2p FIFO controller.
//   DEF_*        : default widths and threshold used by the top-level parameters
//   fifo_flags_t : registered status flags (empty / full / almost_full)
//   fifo_depth() : depth of a RAM with the given address width
package iob_fifo_sync_t2p_ctrl_pkg;

  localparam int DEF_DATA_W         = 21;
  localparam int DEF_ADDR_W         = 21;
  localparam int DEF_FIFO_DEPTH     = 2 ** DEF_ADDR_W;
  localparam int DEF_ALMOST_FULL_TH = DEF_FIFO_DEPTH - 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } fifo_flags_t;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/iob_fifo_sync_t2p_ctrl_if.sv
// Push/pop FIFO bus between producer/consumer logic and the controller.
// Signal suffixes are from the controller's point of view.
//   slave  : controller side (takes requests, drives status and read data)
//   master : producer/consumer side
interface iob_fifo_sync_t2p_ctrl_if #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 21
) ();

  logic              w_en_i;
  logic [DATA_W-1:0] w_data_i;
  logic              w_full_o;
  logic              almost_full_o;
  logic              r_en_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_valid_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o;
  logic              underflow_o;

  modport slave (
    input  w_en_i, w_data_i, r_en_i,
    output w_full_o, almost_full_o, r_data_o, r_valid_o, r_empty_o,
           level_o, overflow_o, underflow_o
  );

  modport master (
    output w_en_i, w_data_i, r_en_i,
    input  w_full_o, almost_full_o, r_data_o, r_valid_o, r_empty_o,
           level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/iob_counter_updown.sv
// Up/down counter with synchronous clear, clock enable and async reset.
//   clk_i/arst_i : clock, asynchronous active-high reset
//   cke_i        : load enable for the count register
//   clr_i        : synchronous clear (wins over inc/dec)
//   inc_i/dec_i  : count +1 / -1 (caller keeps them mutually exclusive)
//   cnt_o        : registered count
//   cnt_nxt_o    : value loaded at the next enabled edge
module iob_counter_updown #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
    else if (dec_i) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     cnt_q <= '0;
    else if (cke_i) cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/iob_fifo_sync_t2p_ctrl.sv
// Synchronous FIFO controller for an external true two-port RAM with a
// registered read port. Owns pointers, occupancy and flags; pop data comes
// straight from the RAM output, one cycle after an accepted pop.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   cke_i         : clock enable (all state holds, no RAM enables when low)
//   rst_i         : synchronous clear, qualified by cke_i
//   fifo_if       : push/pop bus (slave side)
//   ext_mem_*     : RAM write port, read port and registered read data
module iob_fifo_sync_t2p_ctrl
  import iob_fifo_sync_t2p_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int ALMOST_FULL_TH = fifo_depth(ADDR_W) - 1
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  iob_fifo_sync_t2p_ctrl_if.slave fifo_if,
  output logic                    ext_mem_w_en_o,
  output logic [ADDR_W-1:0]       ext_mem_w_addr_o,
  output logic [DATA_W-1:0]       ext_mem_w_data_o,
  output logic                    ext_mem_r_en_o,
  output logic [ADDR_W-1:0]       ext_mem_r_addr_o,
  input  logic [DATA_W-1:0]       ext_mem_r_data_i
);

  localparam int              FIFO_DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] AF_TH_L    = (ADDR_W+1)'(ALMOST_FULL_TH);
  localparam fifo_flags_t     FLAGS_RST  = '{empty: 1'b1, full: 1'b0,
                                             almost_full: (ALMOST_FULL_TH == 0)};

  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  fifo_flags_t       flags_q, flags_d;
  logic              r_valid_q, r_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W:0]   level, level_nxt;
  logic              push_ok, pop_ok;

  // Accepts look only at registered flags, so a push at full is rejected
  // even when a pop frees a slot in the same cycle (and vice versa at empty).
  assign push_ok = cke_i & fifo_if.w_en_i & ~flags_q.full;
  assign pop_ok  = cke_i & fifo_if.r_en_i & ~flags_q.empty;

  iob_counter_updown #(.W(ADDR_W + 1)) u_level (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .cke_i     (cke_i),
    .clr_i     (rst_i),
    .inc_i     (push_ok & ~pop_ok),
    .dec_i     (pop_ok & ~push_ok),
    .cnt_o     (level),
    .cnt_nxt_o (level_nxt)
  );

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    r_valid_d   = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    // level_nxt is already 0 under rst_i, so flags need no special case
    flags_d.empty       = (level_nxt == '0);
    flags_d.full        = (level_nxt == DEPTH_L);
    flags_d.almost_full = (level_nxt >= AF_TH_L);
    if (rst_i) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
    end else begin
      if (push_ok) w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (pop_ok)  r_ptr_d = r_ptr_q + ADDR_W'(1);
      r_valid_d   = pop_ok;
      overflow_d  = fifo_if.w_en_i & flags_q.full;
      underflow_d = fifo_if.r_en_i & flags_q.empty;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      flags_q     <= FLAGS_RST;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (cke_i) begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      flags_q     <= flags_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ext_mem_w_en_o   = push_ok;
  assign ext_mem_w_addr_o = w_ptr_q;
  assign ext_mem_w_data_o = fifo_if.w_data_i;
  assign ext_mem_r_en_o   = pop_ok;
  assign ext_mem_r_addr_o = r_ptr_q;

  assign fifo_if.w_full_o      = flags_q.full;
  assign fifo_if.almost_full_o = flags_q.almost_full;
  assign fifo_if.r_empty_o     = flags_q.empty;
  assign fifo_if.level_o       = level;
  assign fifo_if.r_valid_o     = r_valid_q;
  assign fifo_if.r_data_o      = ext_mem_r_data_i;
  assign fifo_if.overflow_o    = overflow_q;
  assign fifo_if.underflow_o   = underflow_q;

endmodule
